// File: rtl/sort_stream_out.sv
// Output unloader for the sorter: captures a parallel result vector and streams it
// word by word on a valid/ready interface, with one pending slot and a sticky drop flag.
module sort_stream_out #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned WIDTH      = 32,
  parameter bit          FIRST_HIGH = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     vec_valid_in,
  input  logic [WIDTH-1:0]         vec_in [DEPTH-1:0],
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic [$clog2(DEPTH)-1:0] out_index,
  output logic                     busy,
  input  logic                     clr_overflow,
  output logic                     overflow
);

  localparam int unsigned CW = $clog2(DEPTH);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] active      [DEPTH-1:0];
  logic [WIDTH-1:0] active_nxt  [DEPTH-1:0];
  logic [WIDTH-1:0] pending     [DEPTH-1:0];
  logic [WIDTH-1:0] pending_nxt [DEPTH-1:0];
  logic             pending_full, pending_full_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             overflow_nxt;
  logic [CW-1:0]    idx_nxt;
  logic             fire, last_beat;

  assign fire      = out_valid & out_ready;
  assign last_beat = (cnt == CW'(DEPTH - 1));

  // Next-state: buffer hand-off, beat counting and drop detection.
  always_comb begin
    state_nxt        = state;
    active_nxt       = active;
    pending_nxt      = pending;
    pending_full_nxt = pending_full;
    cnt_nxt          = cnt;
    overflow_nxt     = overflow & ~clr_overflow;

    unique case (state)
      IDLE: begin
        if (vec_valid_in) begin
          active_nxt = vec_in;
          cnt_nxt    = '0;
          state_nxt  = STREAM;
        end
      end
      STREAM: begin
        if (fire && last_beat) begin
          cnt_nxt = '0;
          if (pending_full) begin
            active_nxt = pending;
            if (vec_valid_in) begin
              pending_nxt = vec_in;
            end else begin
              pending_full_nxt = 1'b0;
            end
          end else if (vec_valid_in) begin
            active_nxt = vec_in;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          if (fire) begin
            cnt_nxt = cnt + CW'(1);
          end
          if (vec_valid_in) begin
            if (pending_full) begin
              overflow_nxt = 1'b1;
            end else begin
              pending_nxt      = vec_in;
              pending_full_nxt = 1'b1;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    idx_nxt = FIRST_HIGH ? (CW'(DEPTH - 1) - cnt_nxt) : cnt_nxt;
  end

  // State and registered stream outputs, presented from the next-cycle view.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      active       <= '{default: '0};
      pending      <= '{default: '0};
      pending_full <= 1'b0;
      cnt          <= '0;
      overflow     <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_index    <= '0;
      out_last     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nxt;
      active       <= active_nxt;
      pending      <= pending_nxt;
      pending_full <= pending_full_nxt;
      cnt          <= cnt_nxt;
      overflow     <= overflow_nxt;
      out_valid    <= (state_nxt == STREAM);
      out_data     <= (state_nxt == STREAM) ? active_nxt[idx_nxt] : '0;
      out_index    <= (state_nxt == STREAM) ? idx_nxt : '0;
      out_last     <= (state_nxt == STREAM) && (cnt_nxt == CW'(DEPTH - 1));
      busy         <= (state_nxt == STREAM) | pending_full_nxt;
    end
  end

endmodule
